mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequences data-memory accesses for the instruction held in the EX/MEM pipeline register. It drives a multi-cycle, ready-handshaked data memory, stalls the pipeline while an access is outstanding, and delivers load data for the MEM/WB register. It also flags misaligned accesses and memory timeouts. It sits between the EX/MEM register outputs and the data memory port.

## Interface
- TIMEOUT, 16: ACCESS cycles without `mem_ready` before a bus error is raised (≥2).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- exmem_valid  in  1  EX/MEM holds a valid instruction.
- exmem_memread  in  1  instruction is a load.
- exmem_memwrite  in  1  instruction is a store (memread and memwrite are never both 1).
- exmem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- exmem_unsigned  in  1  zero-extend load data (else sign-extend).
- exmem_aluresult  in  32  effective address.
- exmem_wdata  in  32  store data, right-aligned.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write enable, valid with mem_req.
- mem_addr  out  32  word address ({addr[31:2],2'b00}), registered.
- mem_be  out  4  byte enables, registered.
- mem_wdata  out  32  store data replicated into lanes, registered.
- mem_ready  in  1  memory completes the request this cycle.
- mem_rdata  in  32  read word, valid when mem_ready=1.
- load_data  out  32  extended load result, valid with load_valid.
- load_valid  out  1  one-cycle pulse, load complete.
- align_err  out  1  one-cycle pulse, misaligned access suppressed.
- bus_err  out  1  one-cycle pulse, access timed out.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- In IDLE, `need = exmem_valid & (memread|memwrite)`.
- Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
- IDLE, need and aligned: stall=1 combinationally. Register mem_req=1, mem_we=memwrite, mem_addr, mem_be and mem_wdata. Go to ACCESS.
- IDLE, need and misaligned: align_err=1, no request, stall=0, stay in IDLE.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- mem_wdata: byte replicated ×4, half ×2, word as is.
- ACCESS: stall=1, request outputs held stable.
  - On mem_ready, capture the extracted and extended load lane into load_data, clear mem_req and go to DONE.
  - When the wait counter reaches TIMEOUT-1 without mem_ready: clear mem_req, go to DONE with the error flag set.
  - If mem_ready and timeout occur in the same cycle, mem_ready wins.
- DONE: stall=0 so the pipeline advances. One-cycle pulse of load_valid (loads only) or bus_err (on timeout; load_valid stays 0). Go to IDLE.
- Load extraction: select lane by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extend per exmem_unsigned.
- No `need`: stall=0 and all pulses are 0.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, load_data 0, load_valid 0, bus_err 0. align_err and stall are combinational and evaluate to 0 in IDLE with no need.
- Reset asserted mid-access clears mem_req asynchronously. The abandoned transaction is not retried.
- Minimum access (ready on the first ACCESS cycle): cycle 0 IDLE with stall; cycle 1 ACCESS with req and ready; cycle 2 DONE with load_valid, stall=0. Stall cycles = 2 + wait cycles.
- Back-to-back memory instructions: the next instruction enters EX/MEM on the DONE edge and is seen in IDLE the following cycle. No bubble is inserted by this block.
- The wait counter resets on ACCESS entry. A timeout fires after TIMEOUT ACCESS cycles, giving TIMEOUT+1 total stall cycles.
- mem_ready is ignored outside ACCESS.

## Test plan
- Word load at 0x100, ready on first ACCESS cycle, mem_rdata=0xDEADBEEF → stall high for 2 cycles; load_data=0xDEADBEEF with load_valid in the third cycle.
- Signed byte load at 0x103, rdata=0x80112233 → be=1000, load_data=0xFFFFFF80; with exmem_unsigned=1 → 0x00000080.
- Half store 0xABCD at 0x102, ready after 3 waits → mem_we=1, be=1100, wdata=0xABCDABCD, stall 5 cycles, no load_valid.
- Word load at 0x101 → align_err pulse, mem_req never asserted, stall 0.
- Load with mem_ready held low, TIMEOUT=4 → mem_req high 4 cycles, bus_err pulse, no load_valid, pipeline released.
- rst asserted in the second ACCESS cycle → mem_req=0 immediately, state IDLE; a following load completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between mem_access_ctrl (master) and the data memory (slave).
// master drives the registered request fields; slave returns mem_ready/mem_rdata.
//   mem_req    request, held until the memory answers or the access times out
//   mem_we     write enable, valid with mem_req
//   mem_addr   word-aligned address
//   mem_be     byte enables
//   mem_wdata  store data replicated into the addressed lanes
//   mem_ready  memory completes the request this cycle
//   mem_rdata  read word, valid when mem_ready=1
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences the data-memory access of the instruction in EX/MEM.
// Stalls the pipeline while a request is outstanding, extracts and extends
// load data, and flags misaligned accesses and memory timeouts.
//   clk, rst              clock, asynchronous active-high reset
//   exmem_*               EX/MEM register fields (valid, load/store, size,
//                         unsigned, effective address, store data)
//   stall                 freeze PC and upstream pipeline registers
//   mem                   data-memory bus (master side)
//   load_data/load_valid  extended load result, one-cycle pulse
//   align_err             one-cycle pulse, misaligned access suppressed
//   bus_err               one-cycle pulse, access timed out
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exmem_valid,
  input  logic                     exmem_memread,
  input  logic                     exmem_memwrite,
  input  logic [1:0]               exmem_size,
  input  logic                     exmem_unsigned,
  input  logic [31:0]              exmem_aluresult,
  input  logic [31:0]              exmem_wdata,
  output logic                     stall,
  mem_access_ctrl_if.master        mem,
  output logic [31:0]              load_data,
  output logic                     load_valid,
  output logic                     align_err,
  output logic                     bus_err
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          load_valid_q, load_valid_d;
  logic          bus_err_q, bus_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Byte offset, size and extension mode kept for lane extraction at completion.
  logic [1:0]    lo_q, lo_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;

  logic          need;
  logic          misaligned;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    need       = exmem_valid & (exmem_memread | exmem_memwrite);
    misaligned = ((exmem_size == 2'b01) & exmem_aluresult[0]) |
                 (exmem_size[1] & (|exmem_aluresult[1:0]));
    case (exmem_size)
      2'b00: begin
        be_calc    = 4'b0001 << exmem_aluresult[1:0];
        wdata_calc = {4{exmem_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = exmem_aluresult[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{exmem_wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = exmem_wdata;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    size_d       = size_q;
    uns_d        = uns_q;
    stall        = 1'b0;
    align_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (need) begin
          if (misaligned) begin
            align_err = 1'b1;
          end else begin
            stall   = 1'b1;
            req_d   = 1'b1;
            we_d    = exmem_memwrite;
            addr_d  = {exmem_aluresult[31:2], 2'b00};
            be_d    = be_calc;
            wdata_d = wdata_calc;
            lo_d    = exmem_aluresult[1:0];
            size_d  = exmem_size;
            uns_d   = exmem_unsigned;
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        // The completion pulses are registered on the way out so they are
        // visible exactly during the DONE cycle.
        if (mem.mem_ready) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            load_data_d  = extend_load(mem.mem_rdata, size_q, lo_q, uns_q);
            load_valid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= '0;
      lo_q         <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
  assign load_data     = load_data_q;
  assign load_valid    = load_valid_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exmem_valid = 1'b0;
  logic        exmem_memread = 1'b0;
  logic        exmem_memwrite = 1'b0;
  logic [1:0]  exmem_size = 2'b00;
  logic        exmem_unsigned = 1'b0;
  logic [31:0] exmem_aluresult = '0;
  logic [31:0] exmem_wdata = '0;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        align_err;
  logic        bus_err;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .exmem_valid     (exmem_valid),
    .exmem_memread   (exmem_memread),
    .exmem_memwrite  (exmem_memwrite),
    .exmem_size      (exmem_size),
    .exmem_unsigned  (exmem_unsigned),
    .exmem_aluresult (exmem_aluresult),
    .exmem_wdata     (exmem_wdata),
    .stall           (stall),
    .mem             (bus),
    .load_data       (load_data),
    .load_valid      (load_valid),
    .align_err       (align_err),
    .bus_err         (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        lv;
    logic        berr;
    logic        aerr;
    logic [31:0] ld;
    int          req_cycles;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: answers after mem_waits request cycles (negative = never).
  int          mem_waits = -1;
  logic [31:0] mem_word  = '0;
  int          acc_cnt   = 0;

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        bus.mem_ready = (mem_waits >= 0) && (acc_cnt == mem_waits);
        bus.mem_rdata = bus.mem_ready ? mem_word : 32'hA5A5_5A5A;
        acc_cnt++;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hA5A5_5A5A;
        acc_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: checks request fields on the first request cycle and
  // pops the expected result when the request drops or an align error shows.
  bit req_seen = 0;
  int req_cnt  = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_seen = 0;
        req_cnt  = 0;
      end else begin
        if (bus.mem_req) begin
          if (!req_seen) begin
            if (sb.size() == 0) begin
              check("req_without_op", 32'd1, 32'd0);
            end else begin
              e = sb[0];
              check($sformatf("op%0d_we", e.id),    {31'b0, bus.mem_we}, {31'b0, e.we});
              check($sformatf("op%0d_addr", e.id),  bus.mem_addr, e.addr);
              check($sformatf("op%0d_be", e.id),    {28'b0, bus.mem_be}, {28'b0, e.be});
              check($sformatf("op%0d_wdata", e.id), bus.mem_wdata, e.wdata);
            end
            req_seen = 1;
          end
          req_cnt++;
        end
        if ((req_seen && !bus.mem_req) || align_err) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
          end else begin
            e = sb.pop_front();
            check($sformatf("op%0d_load_valid", e.id), {31'b0, load_valid}, {31'b0, e.lv});
            check($sformatf("op%0d_bus_err", e.id),    {31'b0, bus_err},    {31'b0, e.berr});
            check($sformatf("op%0d_align_err", e.id),  {31'b0, align_err},  {31'b0, e.aerr});
            check($sformatf("op%0d_req_cycles", e.id), req_cnt, e.req_cycles);
            if (e.lv) check($sformatf("op%0d_load_data", e.id), load_data, e.ld);
          end
          req_seen = 0;
          req_cnt  = 0;
        end else if (load_valid || bus_err) begin
          check("stray_pulse", 32'd1, 32'd0);
        end
      end
    end
  end

  // kind: 0 completes, 1 misaligned, 2 times out, 3 no memory op
  task automatic run_op(input int id, input bit rd, input bit wr, input logic [1:0] size,
                        input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rword, input int waits, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_ld, input int kind,
                        input int e_stall);
    exp_t e;
    int   cnt;
    bit   released;
    if (kind != 3) begin
      e.id         = id;
      e.we         = wr;
      e.addr       = {addr[31:2], 2'b00};
      e.be         = e_be;
      e.wdata      = e_wd;
      e.lv         = (kind == 0) && rd;
      e.berr       = (kind == 2);
      e.aerr       = (kind == 1);
      e.ld         = e_ld;
      e.req_cycles = (kind == 0) ? waits + 1 : (kind == 2) ? int'(TO) : 0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    exmem_valid     = 1'b1;
    exmem_memread   = rd;
    exmem_memwrite  = wr;
    exmem_size      = size;
    exmem_unsigned  = uns;
    exmem_aluresult = addr;
    exmem_wdata     = wdata;
    mem_waits       = waits;
    mem_word        = rword;
    cnt = 0;
    released = 0;
    for (int c = 0; c < 40 && !released; c++) begin
      @(negedge clk);
      if (stall) cnt++;
      else released = 1;
    end
    if (!released) check($sformatf("op%0d_stall_release", id), 32'd0, 32'd1);
    check($sformatf("op%0d_stall_cycles", id), cnt, e_stall);
  endtask

  initial begin
    exp_t e;
    #2;
    check("rst_mem_req",    {31'b0, bus.mem_req}, 32'd0);
    check("rst_mem_we",     {31'b0, bus.mem_we},  32'd0);
    check("rst_mem_addr",   bus.mem_addr,         32'd0);
    check("rst_mem_be",     {28'b0, bus.mem_be},  32'd0);
    check("rst_mem_wdata",  bus.mem_wdata,        32'd0);
    check("rst_load_data",  load_data,            32'd0);
    check("rst_load_valid", {31'b0, load_valid},  32'd0);
    check("rst_bus_err",    {31'b0, bus_err},     32'd0);
    check("rst_align_err",  {31'b0, align_err},   32'd0);
    check("rst_stall",      {31'b0, stall},       32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    //     id rd wr size   uns addr          wdata         rword        wt  be       mwdata        ld            kind stall
    run_op(1, 1, 0, 2'b10, 0, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 2);
    run_op(2, 1, 0, 2'b00, 0, 32'h0000_0103, 32'h0,        32'h80112233, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 2);
    run_op(3, 1, 0, 2'b00, 1, 32'h0000_0103, 32'h0,        32'h80112233, 0, 4'b1000, 32'h0,        32'h00000080, 0, 2);
    run_op(4, 0, 1, 2'b01, 0, 32'h0000_0102, 32'h0000ABCD, 32'h0,        3, 4'b1100, 32'hABCDABCD, 32'h0,        0, 5);
    run_op(5, 1, 0, 2'b10, 0, 32'h0000_0101, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 0);
    run_op(6, 1, 0, 2'b10, 0, 32'h0000_0200, 32'h0,        32'h0,       -1, 4'b1111, 32'h0,        32'h0,        2, 5);
    run_op(7, 1, 0, 2'b01, 0, 32'h0000_0106, 32'h0,        32'h80017FFF, 1, 4'b1100, 32'h0,        32'hFFFF8001, 0, 3);
    run_op(8, 1, 0, 2'b01, 1, 32'h0000_0104, 32'h0,        32'h1234F00D, 0, 4'b0011, 32'h0,        32'h0000F00D, 0, 2);
    run_op(9, 0, 1, 2'b00, 0, 32'h0000_0301, 32'hFFFFFF5A, 32'h0,        1, 4'b0010, 32'h5A5A5A5A, 32'h0,        0, 3);
    run_op(10, 1, 0, 2'b00, 0, 32'h0000_0302, 32'h0,       32'h00117F00, 2, 4'b0100, 32'h0,        32'h00000011, 0, 4);
    run_op(11, 0, 1, 2'b01, 0, 32'h0000_0203, 32'h1111,    32'h0,        0, 4'b0000, 32'h0,        32'h0,        1, 0);
    run_op(12, 0, 1, 2'b11, 0, 32'h0000_0400, 32'h12345678, 32'h0,       2, 4'b1111, 32'h12345678, 32'h0,        0, 4);
    run_op(13, 1, 0, 2'b00, 0, 32'h0000_0000, 32'h0,       32'h000000FF, 0, 4'b0001, 32'h0,        32'hFFFFFFFF, 0, 2);
    run_op(14, 0, 0, 2'b10, 0, 32'h0000_0700, 32'h0,       32'h0,        0, 4'b0000, 32'h0,        32'h0,        3, 0);

    // Reset in the second ACCESS cycle abandons the load.
    e.id = 20; e.we = 1'b0; e.addr = 32'h0000_0500; e.be = 4'b1111; e.wdata = 32'h0;
    e.lv = 1'b0; e.berr = 1'b0; e.aerr = 1'b0; e.ld = 32'h0; e.req_cycles = 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    exmem_valid = 1'b1; exmem_memread = 1'b1; exmem_memwrite = 1'b0;
    exmem_size = 2'b10; exmem_unsigned = 1'b0; exmem_aluresult = 32'h0000_0500;
    mem_waits = -1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    check("pre_rst_mem_req", {31'b0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    exmem_valid = 1'b0;
    #1;
    check("midrst_mem_req",    {31'b0, bus.mem_req}, 32'd0);
    check("midrst_stall",      {31'b0, stall},       32'd0);
    check("midrst_load_valid", {31'b0, load_valid},  32'd0);
    check("midrst_bus_err",    {31'b0, bus_err},     32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    #2 rst = 1'b0;
    run_op(21, 1, 0, 2'b10, 0, 32'h0000_0500, 32'h0, 32'hCAFEF00D, 0, 4'b1111, 32'h0, 32'hCAFEF00D, 0, 2);

    @(posedge clk);
    #1 exmem_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
